// File: rtl/initram_loader.sv
// initram_loader: power-up copier from a synchronous image ROM into word-addressed RAM.
// Copies WORDS words to RAM_BASE, honours RAM back-pressure, restarts on start_load.
// Optional read-back verify pass is compiled in when INITRAM_VERIFY_EN is defined.
module initram_loader #(
    parameter int unsigned ROM_AW   = 14,
    parameter int unsigned WORDS    = 4096,
    parameter logic [31:0] RAM_BASE = 32'h0000_0000
) (
    input  logic              clk_load,
    input  logic              KEY,
    input  logic              start_load,
    input  logic [31:0]       data_out_rom,
    input  logic              ram_ready,
    input  logic [31:0]       data_out_ram,
    output logic [ROM_AW-1:0] addr_rom,
    output logic [31:0]       addr_ram,
    output logic [31:0]       data_in_ram,
    output logic [3:0]        byte_en,
    output logic              ram_we,
    output logic              busy,
    output logic              load_done,
    output logic              verify_err
);

    // One extra bit so WORDS == 2**ROM_AW is representable without wrapping.
    localparam int unsigned KW = ROM_AW + 1;
    localparam logic [KW-1:0] LastK = KW'(WORDS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StWrite  = 3'd2,
`ifdef INITRAM_VERIFY_EN
        StVFetch = 3'd3,
        StVCheck = 3'd4,
`endif
        StDone   = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [31:0]   word_addr;

    assign word_addr = RAM_BASE + (32'(k_q) << 2);
    assign addr_rom  = k_q[ROM_AW-1:0];
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign load_done = (state_q == StDone);

`ifdef INITRAM_VERIFY_EN
    logic verr_q, verr_d;
    assign verify_err = verr_q;
`else
    logic unused_ram_rd;
    assign unused_ram_rd = ^data_out_ram;
    assign verify_err    = 1'b0;
`endif

    // State, word index and sticky verify flag; reset aborts any copy or verify.
    always_ff @(posedge clk_load or negedge KEY) begin
        if (!KEY) begin
            state_q <= StIdle;
            k_q     <= '0;
`ifdef INITRAM_VERIFY_EN
            verr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
`ifdef INITRAM_VERIFY_EN
            verr_q  <= verr_d;
`endif
        end
    end

    // Next-state and RAM-side outputs; outside WRITE the write port is quiet.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
`ifdef INITRAM_VERIFY_EN
        verr_d      = verr_q;
`endif
        ram_we      = 1'b0;
        byte_en     = 4'b0000;
        addr_ram    = 32'h0;
        data_in_ram = 32'h0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_load) begin
                    k_d     = '0;
                    state_d = StFetch;
`ifdef INITRAM_VERIFY_EN
                    verr_d  = 1'b0;
`endif
                end
            end
            StFetch: state_d = StWrite;
            StWrite: begin
                ram_we      = 1'b1;
                byte_en     = 4'b1111;
                addr_ram    = word_addr;
                // ROM address is held through WRITE, so its data stays stable under stall.
                data_in_ram = data_out_rom;
                if (ram_ready) begin
                    if (k_q == LastK) begin
`ifdef INITRAM_VERIFY_EN
                        k_d     = '0;
                        state_d = StVFetch;
`else
                        state_d = StDone;
`endif
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
`ifdef INITRAM_VERIFY_EN
            StVFetch: begin
                addr_ram = word_addr;
                state_d  = StVCheck;
            end
            StVCheck: begin
                addr_ram = word_addr;
                if (data_out_rom != data_out_ram) verr_d = 1'b1;
                if (k_q == LastK) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StVFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_initram_loader.sv
// Scoreboard bench for initram_loader: the stimulus pushes expected RAM writes and the
// expected load_done cycle; a negedge monitor pops and compares as the DUT produces them.
module tb_initram_loader;

    localparam int unsigned ROM_AW = 3;
    localparam int unsigned WORDS  = 8;
    localparam logic [31:0] BASE   = 32'h100;
`ifdef INITRAM_VERIFY_EN
    localparam bit VerifyEn = 1'b1;
`else
    localparam bit VerifyEn = 1'b0;
`endif

    logic              clk_load = 1'b0;
    logic              KEY = 1'b1;
    logic              start_load = 1'b0;
    logic              ram_ready = 1'b0;
    logic [31:0]       data_out_rom;
    logic [31:0]       data_out_ram;
    logic [ROM_AW-1:0] addr_rom;
    logic [31:0]       addr_ram;
    logic [31:0]       data_in_ram;
    logic [3:0]        byte_en;
    logic              ram_we;
    logic              busy;
    logic              load_done;
    logic              verify_err;

    initram_loader #(
        .ROM_AW  (ROM_AW),
        .WORDS   (WORDS),
        .RAM_BASE(BASE)
    ) dut (
        .clk_load    (clk_load),
        .KEY         (KEY),
        .start_load  (start_load),
        .data_out_rom(data_out_rom),
        .ram_ready   (ram_ready),
        .data_out_ram(data_out_ram),
        .addr_rom    (addr_rom),
        .addr_ram    (addr_ram),
        .data_in_ram (data_in_ram),
        .byte_en     (byte_en),
        .ram_we      (ram_we),
        .busy        (busy),
        .load_done   (load_done),
        .verify_err  (verify_err)
    );

    initial forever #5 clk_load = ~clk_load;

    int unsigned cyc = 0;
    always @(posedge clk_load) cyc <= cyc + 1;

    // Memory models: synchronous ROM, RAM with write port and latency-1 read.
    logic [31:0] rom [WORDS];
    logic [31:0] mem [WORDS];
    bit          corrupt = 1'b0;
    logic [31:0] ram_off;
    assign ram_off = (addr_ram - BASE) >> 2;

    always @(posedge clk_load) data_out_rom <= rom[addr_rom];
    always @(posedge clk_load) begin
        if (ram_we && ram_ready) mem[ram_off[2:0]] <= data_in_ram;
        data_out_ram <= mem[ram_off[2:0]] ^ ((corrupt && ram_off[2:0] == 3'd5) ? 32'h1 : 32'h0);
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        int unsigned cyc;
        logic        verr;
    } done_t;
    wr_t   exp_q[$];
    done_t done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr_rom"}, 32'(addr_rom), 32'h0);
        check({tag, "_addr_ram"}, addr_ram, 32'h0);
        check({tag, "_data_in_ram"}, data_in_ram, 32'h0);
        check({tag, "_byte_en"}, 32'(byte_en), 32'h0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_load_done"}, 32'(load_done), 32'h0);
        check({tag, "_verify_err"}, 32'(verify_err), 32'h0);
    endtask

    // Monitor: write scoreboard, stall-hold check and load_done completion check.
    initial begin
        wr_t         e;
        done_t       d;
        logic        ld_prev;
        logic        stall_prev;
        logic [31:0] stall_addr;
        logic [31:0] stall_data;
        ld_prev    = 1'b0;
        stall_prev = 1'b0;
        stall_addr = 32'h0;
        stall_data = 32'h0;
        forever begin
            @(negedge clk_load);
            if (!KEY) begin
                ld_prev    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("bp_hold_we", 32'(ram_we), 32'h1);
                    check("bp_hold_addr", addr_ram, stall_addr);
                    check("bp_hold_data", data_in_ram, stall_data);
                end
                if (ram_we && ram_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr %h, required no write", addr_ram);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", addr_ram, e.addr);
                        check("wr_data", data_in_ram, e.data);
                        check("wr_byte_en", 32'(byte_en), 32'hF);
                    end
                end
                if (!ram_we) begin
                    check("idle_data_in_ram", data_in_ram, 32'h0);
                    check("idle_byte_en", 32'(byte_en), 32'h0);
                end
                stall_prev = ram_we && !ram_ready;
                stall_addr = addr_ram;
                stall_data = data_in_ram;
                if (load_done && !ld_prev) begin
                    if (done_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got load_done at cycle %0d, required none", cyc);
                    end else begin
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d.cyc);
                        check("done_verify_err", 32'(verify_err), 32'(d.verr));
                        check("done_all_written", exp_q.size(), 32'h0);
                        check("done_addr_rom", 32'(addr_rom), WORDS - 1);
                        check("done_busy", 32'(busy), 32'h0);
                        check("done_addr_ram", addr_ram, 32'h0);
                    end
                end
                ld_prev = load_done;
            end
        end
    end

    // One copy run. rdy_rand: random back-pressure; bp_t/bp_len: forced stall window;
    // pulse_mode: 0 none, 1 random busy-time start, 2 start on the final-accept edge;
    // abort_t: cycle at which KEY is pulled low (-1 none). Entered/left at posedge+1.
    task automatic run_copy(input bit rdy_rand, input int bp_t, input int bp_len,
                            input int pulse_mode, input bit corr, input int abort_t);
        bit          rdy [256];
        int          t;
        int          pulse_t;
        int unsigned e0;
        wr_t         e;
        done_t       d;
        for (int i = 0; i < 256; i++)
            rdy[i] = (!rdy_rand || i >= 200) ? 1'b1 : ($urandom_range(2, 0) != 0);
        for (int i = 0; i < bp_len; i++) rdy[bp_t + i] = 1'b0;
        // Reference timing: per word one fetch cycle, then write cycles until accepted.
        t = 0;
        for (int w = 0; w < int'(WORDS); w++) begin
            t++;
            while (!rdy[t]) t++;
            t++;
        end
        if (VerifyEn) t += 2 * int'(WORDS);
        pulse_t = (pulse_mode == 1) ? int'($urandom_range(t - 1, 0)) :
                  (pulse_mode == 2) ? t - 1 : -1;
        corrupt = corr;
        for (int w = 0; w < int'(WORDS); w++) begin
            e.addr = BASE + 32'(w) * 4;
            e.data = rom[w];
            exp_q.push_back(e);
        end
        start_load = 1'b1;
        ram_ready  = 1'b1;
        @(posedge clk_load);
        #1;
        e0 = cyc;
        start_load = 1'b0;
        check("start_clears_done", 32'(load_done), 32'h0);
        check("start_sets_busy", 32'(busy), 32'h1);
        check("start_clears_verr", 32'(verify_err), 32'h0);
        d.cyc  = e0 + t;
        d.verr = VerifyEn && corr;
        done_q.push_back(d);
        for (int i = 0; i <= t + 2; i++) begin
            if (i == abort_t) begin
                ram_ready = 1'b1;
                #2;
                KEY = 1'b0;
                #1;
                check_all_zero("abort");
                exp_q.delete();
                done_q.delete();
                repeat (3) @(posedge clk_load);
                #1;
                KEY = 1'b1;
                repeat (4) begin
                    @(posedge clk_load);
                    #1;
                end
                check("post_abort_busy", 32'(busy), 32'h0);
                check("post_abort_done", 32'(load_done), 32'h0);
                return;
            end
            ram_ready  = rdy[i];
            start_load = (i == pulse_t);
            @(posedge clk_load);
            #1;
        end
        start_load = 1'b0;
        if (done_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no load_done by cycle %0d, required cycle %0d",
                     cyc, e0 + t);
            done_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        for (int w = 0; w < int'(WORDS); w++) rom[w] = 32'hA5A5_0000 + 32'(w);
        #2;
        KEY = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk_load);
        @(posedge clk_load);
        #1;
        KEY = 1'b1;
        repeat (2) begin
            @(posedge clk_load);
            #1;
        end
        check("idle_busy", 32'(busy), 32'h0);

        run_copy(1'b0, -1, 0, 0, 1'b0, -1);  // basic copy, 16 cycles
        run_copy(1'b0, 5, 3, 0, 1'b0, -1);   // stall on word 2, restart from DONE, 19 cycles
        run_copy(1'b0, -1, 0, 0, 1'b0, 9);   // reset during word 4
        run_copy(1'b0, -1, 0, 0, 1'b0, -1);  // full copy after abort
        run_copy(1'b0, -1, 0, 0, 1'b1, -1);  // read-back corruption of word 5
        run_copy(1'b0, -1, 0, 2, 1'b0, -1);  // start on final-accept edge is ignored
        repeat (6) begin
            for (int w = 0; w < int'(WORDS); w++) rom[w] = $urandom;
            run_copy(1'b1, -1, 0, 1, 1'(($urandom_range(1, 0))), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
